ex_mul_unit: RTL and testbench
==============================

# ex_mul_unit

Iterative shift-add multiplier in the EX stage, driven by the ID/EX pipeline register's control outputs and operands. It executes MUL instructions over multiple cycles and asserts a stall that freezes PC, IF/ID and ID/EX until the product is ready. It then presents the product to the EX/MEM register for one advancing cycle. The latency is fixed and data-independent, so hazard timing is deterministic.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  a MUL sits in EX, decoded from ID/EX control. Held high for the whole operation because ID/EX is frozen.
- flush_i  input  1  abort the in-flight operation (branch/jump squash of EX).
- src1_i  input  WIDTH  multiplicand (rs data after forwarding).
- src2_i  input  WIDTH  multiplier (rt data after forwarding).
- stall_o  output  1  freeze PC, IF/ID, ID/EX while high.
- done_o  output  1  product valid; high for exactly one cycle per operation.
- result_o  output  WIDTH  low WIDTH bits of the product, written back as MUL rd.
- product_o  output  2*WIDTH  full unsigned product.

## Operation
- Unsigned multiply. result_o is the low WIDTH bits of product_o, which is also correct for two's-complement low-word MUL.
- Internal state: mcand (2*WIDTH), mplier (WIDTH), acc (2*WIDTH), count (clog2(WIDTH)+1 bits), and an FSM with states IDLE, BUSY, DONE.
- **IDLE**
  - If start_i=1 and flush_i=0: latch mcand = zero-extended src1_i, mplier = src2_i, acc = 0, count = 0, then go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**, one step per cycle:
  - If mplier[0] = 1, acc += mcand. Add is 2*WIDTH wide; no carry out is possible.
  - mcand <<= 1, mplier >>= 1, count += 1.
  - When count reaches WIDTH-1 on this edge, go to DONE with the final acc.
  - start_i is ignored in BUSY.
- **DONE**
  - done_o=1. product_o = acc, result_o = acc[WIDTH-1:0].
  - Go to IDLE unconditionally. start_i is ignored, since it is still the completing MUL.
- stall_o = (state==IDLE & start_i & ~flush_i) | (state==BUSY). It is combinational from start_i in IDLE, so the stall applies in the first cycle the MUL sits in EX.
- product_o and result_o hold their last DONE value until the next DONE. They are not cleared on IDLE or on flush.
- flush_i in BUSY: go to IDLE next edge. No done_o, outputs unchanged, stall_o keeps its BUSY value (high) through that cycle.
- flush_i in DONE: done_o still pulses. Squashing the writeback is the EX/MEM register's job.
- Reset, asynchronous on rst_i low:
  - state=IDLE; acc, mcand, mplier, count, product_o, result_o = 0; done_o=0.
  - stall_o is forced 0 while rst_i=0.
  - Reset mid-BUSY abandons the operation with no done_o.

## Timing
- Cycle C0: start_i high in IDLE, stall_o=1. The edge ending C0 latches the operands.
- Cycles C1..CWIDTH: BUSY, stall_o=1. WIDTH iterations.
- Cycle CWIDTH+1: DONE, done_o=1, stall_o=0. The pipeline advances and EX/MEM captures result_o.
- Total: WIDTH+2 cycles in EX; stall_o is high for WIDTH+1 cycles.
- A back-to-back MUL enters EX in CWIDTH+2 and restarts from IDLE. The minimum spacing between done_o pulses is WIDTH+2 cycles.
- done_o and stall_o are never both high.

## Test plan
- Reset, then start_i=1 with src1_i=3, src2_i=5. Required: stall_o high for 33 cycles, done_o in cycle 34, result_o=15, product_o=15.
- src1_i=0xFFFFFFFF, src2_i=0xFFFFFFFF. Required: product_o=0xFFFFFFFE00000001, result_o=0x00000001.
- Operand zero (src1_i=0x1234, src2_i=0). Required: the full 33-cycle stall still occurs, then result_o=0 with done_o for one cycle.
- Two consecutive MULs, 7*6 then 9*9, with start_i held high. Required: done_o pulses 34 cycles apart, result_o=42 then 81, start_i ignored during DONE.
- Assert flush_i in BUSY cycle 10 of 100*2. Required:
  - stall_o drops after the flush edge, no done_o, result_o keeps its previous value.
  - A following 4*4 gives 16.
- Drive rst_i low asynchronously mid-BUSY. Required: outputs clear immediately, stall_o=0, state IDLE. After release, 2*3 completes normally with result_o=6.

Source files
------------

// File: rtl/ex_mul_unit.sv
// Iterative shift-add multiplier for the EX stage. Stalls the front of the pipeline while
// iterating and presents the product for exactly one advancing cycle.
module ex_mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic               stall_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 launch;

  assign launch = (state_q == StIdle) && start_i && !flush_i;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          mcand_d  = {{WIDTH{1'b0}}, src1_i};
          mplier_d = src2_i;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CntW'(1);
          if (count_q == LastCnt) begin
            // Capture the final sum so the product is visible during DONE itself.
            product_d = acc_d;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
    end
  end

  // Stall is combinational from start_i so the first EX cycle of a MUL is already frozen.
  assign stall_o   = rst_i && (launch || (state_q == StBusy));
  assign done_o    = (state_q == StDone);
  assign product_o = product_q;
  assign result_o  = product_q[WIDTH-1:0];

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: table of multiplies through a scoreboard plus
// hand-written back-to-back, flush and asynchronous-reset sequences.
module tb_ex_mul_unit;

  localparam int W = 32;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic           start_i = 1'b0;
  logic           flush_i = 1'b0;
  logic [W-1:0]   src1_i = '0;
  logic [W-1:0]   src2_i = '0;
  logic           stall_o;
  logic           done_o;
  logic [W-1:0]   result_o;
  logic [2*W-1:0] product_o;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];
  logic done_prev = 1'b0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs[8];

  ex_mul_unit #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .flush_i   (flush_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .product_o (product_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every done_o pops one expected product.
  always @(negedge clk_i) begin
    logic [2*W-1:0] e;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_o=1, expected no completion at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_product", product_o, e);
        check("sb_result", {32'h0, result_o}, {32'h0, e[W-1:0]});
      end
      check("done_single_cycle", {63'h0, done_prev}, 64'h0);
      check("done_no_stall", {63'h0, stall_o}, 64'h0);
    end
    done_prev <= done_o;
  end

  // Launch one MUL, count stall cycles up to done_o, optionally keep start_i high afterwards.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                         output time t_done);
    int  stalls;
    bit  got;
    stalls = 0;
    got    = 1'b0;
    t_done = 0;
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    src1_i  = a;
    src2_i  = b;
    exp_q.push_back({32'h0, a} * {32'h0, b});
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        got    = 1'b1;
        t_done = $time;
      end else if (stall_o) begin
        stalls++;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done_o in 100 cycles, expected one for 0x%0h*0x%0h",
               a, b);
    end else begin
      check("stall_cycles", 64'(stalls), 64'(W + 1));
    end
    if (!hold) start_i = 1'b0;
  endtask

  initial begin
    time t0;
    time t1;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{a: 32'd3,         b: 32'd5,         prod: 64'd15};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, prod: 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{a: 32'h1234,      b: 32'd0,         prod: 64'd0};
    vecs[3] = '{a: 32'd0,         b: 32'hDEAD_BEEF, prod: 64'd0};
    vecs[4] = '{a: 32'd1,         b: 32'h8000_0000, prod: 64'h0000_0000_8000_0000};
    vecs[5] = '{a: 32'h8000_0000, b: 32'd2,         prod: 64'h0000_0001_0000_0000};
    for (int i = 6; i < 8; i++) begin
      ra = $urandom();
      rb = $urandom();
      vecs[i] = '{a: ra, b: rb, prod: {32'h0, ra} * {32'h0, rb}};
    end

    // Reset state, with start_i high to show stall is forced low.
    start_i = 1'b1;
    src1_i  = 32'd9;
    src2_i  = 32'd9;
    #12;
    check("rst_stall", {63'h0, stall_o}, 64'h0);
    check("rst_done", {63'h0, done_o}, 64'h0);
    check("rst_product", product_o, 64'h0);
    check("rst_result", {32'h0, result_o}, 64'h0);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 8; i++) begin
      check("table_model", {32'h0, vecs[i].a} * {32'h0, vecs[i].b}, vecs[i].prod);
      run_mul(vecs[i].a, vecs[i].b, 1'b0, t0);
      check("table_product", product_o, vecs[i].prod);
    end

    // Back-to-back with start_i held through DONE.
    run_mul(32'd7, 32'd6, 1'b1, t0);
    check("b2b_first", {32'h0, result_o}, 64'd42);
    run_mul(32'd9, 32'd9, 1'b0, t1);
    check("b2b_second", {32'h0, result_o}, 64'd81);
    check("b2b_spacing", 64'(t1 - t0), 64'(34 * 10));

    // Flush in BUSY cycle 10 of 100*2: no completion, result keeps 81.
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    src1_i  = 32'd100;
    src2_i  = 32'd2;
    @(negedge clk_i);
    for (int c = 0; c < 10; c++) @(negedge clk_i);
    check("flush_busy_stall", {63'h0, stall_o}, 64'h1);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_stall_drop", {63'h0, stall_o}, 64'h0);
    check("flush_no_done", {63'h0, done_o}, 64'h0);
    check("flush_result_kept", {32'h0, result_o}, 64'd81);
    for (int c = 0; c < 40; c++) @(negedge clk_i);
    check("flush_still_idle", {63'h0, stall_o}, 64'h0);
    run_mul(32'd4, 32'd4, 1'b0, t0);
    check("after_flush", {32'h0, result_o}, 64'd16);

    // Asynchronous reset mid-BUSY.
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    src1_i  = 32'd5;
    src2_i  = 32'd5;
    for (int c = 0; c < 6; c++) @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_stall", {63'h0, stall_o}, 64'h0);
    check("arst_done", {63'h0, done_o}, 64'h0);
    check("arst_product", product_o, 64'h0);
    check("arst_result", {32'h0, result_o}, 64'h0);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("arst_idle", {63'h0, stall_o}, 64'h0);
    run_mul(32'd2, 32'd3, 1'b0, t0);
    check("after_arst", {32'h0, result_o}, 64'd6);

    for (int c = 0; c < 5; c++) @(negedge clk_i);
    check("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
